countdown_timer32: RTL and testbench
====================================

# countdown_timer32

Programmable 32-bit down-counting timer, the decrementing counterpart of the free-running 32-bit up counter. Software or a controlling FSM loads a period, starts it, and receives a one-cycle `expire` pulse plus a sticky `irq` flag when the count reaches zero. It supports one-shot and auto-reload modes and has an optional clock prescaler. It serves as the tick/timeout source for the core's timer and watchdog paths.

## Interface
Parameters:
- `PRE_DIV`, default 1: clock cycles per count tick; legal range 1..65536. A value of 1 means decrement every cycle.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-low.
- `load` in 1: load strobe. Writes `load_val` into both the reload register and the count.
- `load_val` in 32: period value.
- `start` in 1: start strobe.
- `stop` in 1: stop strobe.
- `auto_reload` in 1: mode select, sampled on an accepted `start`. 1 selects auto-reload; 0 selects one-shot.
- `irq_ack` in 1: clears `irq`.
- `cnt` out 32: current count.
- `running` out 1: high while in state RUN.
- `expire` out 1: one-cycle pulse on terminal count.
- `irq` out 1: sticky expiry flag.

## Operation
- Internal state:
  - `cnt_q`, `reload_q`: 32 bits each.
  - `mode_q`: latched auto-reload mode.
  - `pre_q`: prescaler count, ceil(log2(PRE_DIV)) bits, minimum 1.
  - FSM with states IDLE, RUN, DONE.
- Reset (`rst`==0 at the edge) forces: `cnt`=0, `reload_q`=0, `mode_q`=0, `pre_q`=0, state IDLE, `running`=0, `expire`=0, `irq`=0. Reset overrides every other input, including in the middle of a count.
- Command priority within one cycle: `load` > `stop` > `start`.
- **load**
  - Sets `reload_q` and `cnt` to `load_val` and clears `pre_q`.
  - If `load_val`==0, the state goes to IDLE.
  - Otherwise the state is unchanged. A load in RUN therefore restarts the period at the new value.
- **stop**
  - In RUN: go to IDLE, hold `cnt`, clear `pre_q`.
  - In IDLE or DONE: no effect.
- **start**
  - Accepted only in IDLE or DONE, and only when `cnt`!=0.
  - Effects of an accepted start: latch `mode_q`<=`auto_reload`, clear `pre_q`, go to RUN.
  - From DONE, where `cnt`==0, start is rejected. The user must load first.
  - Start while already in RUN is ignored.
- **Tick** (RUN only)
  - A tick occurs when `pre_q`==PRE_DIV-1. On a tick `pre_q` wraps to 0; otherwise `pre_q` increments.
  - On a tick with `cnt`>1: `cnt` decrements by 1.
  - On a tick with `cnt`==1: this is terminal count. `expire` is registered high for exactly one cycle, then:
    - auto-reload: `cnt`<=`reload_q` and the state stays RUN, so `cnt` never reads 0;
    - one-shot: `cnt`<=0 and the state goes to DONE.
  - Arithmetic is 32-bit unsigned. `cnt` never wraps below 0.
- **irq**
  - Set on the edge that raises `expire`.
  - Cleared by `irq_ack`.
  - If set and ack occur in the same cycle, set wins and `irq` stays 1.
- **Outputs**
  - `running` is 1 exactly in RUN.
  - `cnt` is the register `cnt_q`, with no combinational path from the inputs.

## Timing
- All outputs are registered.
- Latency from `start` to the first decrement is PRE_DIV edges.
- With `load_val`=L and start accepted at edge N, the first `expire` is high in the cycle after edge N+L·PRE_DIV.
- Auto-reload period is exactly L·PRE_DIV cycles between `expire` pulses, with no gap cycle.
- A load in RUN at edge M restarts the period: the next expire follows edge M+L'·PRE_DIV, where L' is the new value.
- A stop in the same cycle as a terminal-count tick: stop wins, no `expire`, `cnt` holds 1.
- A load in the same cycle as a terminal-count tick: load wins, no `expire`.
- Assertions: `expire` is never high for 2 consecutive cycles when PRE_DIV=1 and L>=2; `running` is never high while `cnt`==0.

## Test plan
- Reset/one-shot: hold `rst`=0 for 2 cycles → all outputs 0. Then load 5, start with `auto_reload`=0, PRE_DIV=1 → `cnt` reads 5,4,3,2,1,0; `expire` is high for one cycle coincident with `cnt`=0; state DONE; `irq`=1 until `irq_ack`.
- Auto-reload: load 3, start with `auto_reload`=1 → `cnt` reads 3,2,1,3,2,1…; `expire` every 3 cycles. Stop mid-count at `cnt`=2 → `running`=0 and `cnt` holds 2. Restart → count resumes at 2.
- Prescaler: PRE_DIV=4, load 2, start → `cnt` changes every 4 cycles; `expire` arrives 8 cycles after start.
- Priority and boundaries:
  - start with `cnt`=0 → rejected;
  - load 0 in RUN → IDLE;
  - stop and start in the same cycle → stop wins;
  - `irq_ack` coincident with `expire` → `irq` stays 1.
- Edge values: load 0xFFFFFFFF, then reload 1 in auto mode → `expire` every cycle and `cnt` constantly 1.
- Reset mid-RUN with `cnt`=0x1234 → next cycle all outputs 0 and IDLE.

Source files
------------

// File: rtl/countdown_timer32.sv
// Programmable 32-bit down-counting timer with a clock prescaler.
// It supports one-shot and auto-reload modes and raises an expire pulse and a sticky irq.
module countdown_timer32 #(
    parameter int unsigned PRE_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        start,
    input  logic        stop,
    input  logic        auto_reload,
    input  logic        irq_ack,
    output logic [31:0] cnt,
    output logic        running,
    output logic        expire,
    output logic        irq
);

    localparam int unsigned PW =
        (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   cnt_q;
    logic [31:0]   reload_q;
    logic          mode_q;
    logic [PW-1:0] pre_q;

    logic tick;
    logic term;
    logic start_ok;

    assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);
    // Load and stop both pre-empt a terminal-count tick.
    assign term     = tick && (cnt_q == 32'd1) && !load && !stop;
    assign start_ok = start && (state_q != RUN) && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            pre_q    <= '0;
            running  <= 1'b0;
            expire   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            expire <= term;
            if (term) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end

            if (load) begin
                reload_q <= load_val;
                cnt_q    <= load_val;
                pre_q    <= '0;
                if (load_val == '0) begin
                    state_q <= IDLE;
                    running <= 1'b0;
                end
            end else if (stop) begin
                if (state_q == RUN) begin
                    state_q <= IDLE;
                    running <= 1'b0;
                    pre_q   <= '0;
                end
            end else if (start_ok) begin
                mode_q  <= auto_reload;
                pre_q   <= '0;
                state_q <= RUN;
                running <= 1'b1;
            end else if (state_q == RUN) begin
                pre_q <= tick ? '0 : pre_q + 1'b1;
                if (term) begin
                    if (mode_q) begin
                        cnt_q <= reload_q;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        running <= 1'b0;
                    end
                end else if (tick && cnt_q > 32'd1) begin
                    cnt_q <= cnt_q - 32'd1;
                end
            end
        end
    end

    assign cnt = cnt_q;

    always @(posedge clk) begin
        if (rst) begin
            assert (!(running && cnt_q == '0));
        end
    end

    // Back-to-back expires are only possible with a reload value of 1.
    assert property (@(posedge clk) disable iff (!rst)
        (PRE_DIV == 1 && reload_q >= 32'd2 && expire) |=> !expire);

endmodule

// File: tb/tb_countdown_timer32.sv
// Scoreboard bench for countdown_timer32.
// Two instances (PRE_DIV 1 and 4) share the stimulus.
module tb_countdown_timer32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] load_val;
    logic        start;
    logic        stop;
    logic        auto_reload;
    logic        irq_ack;

    logic [31:0] cnt0, cnt1;
    logic        running0, running1;
    logic        expire0, expire1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    countdown_timer32 #(.PRE_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .load(load),
        .load_val(load_val), .start(start),
        .stop(stop), .auto_reload(auto_reload),
        .irq_ack(irq_ack), .cnt(cnt0),
        .running(running0), .expire(expire0),
        .irq(irq0)
    );

    countdown_timer32 #(.PRE_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .load(load),
        .load_val(load_val), .start(start),
        .stop(stop), .auto_reload(auto_reload),
        .irq_ack(irq_ack), .cnt(cnt1),
        .running(running1), .expire(expire1),
        .irq(irq1)
    );

    typedef struct packed {
        logic [31:0] cnt;
        logic        run;
        logic        exp;
        logic        irq;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    // Reference model: count value, period bookkeeping in plain cycles.
    int unsigned pdiv[2] = '{1, 4};
    logic [31:0] m_cnt[2];
    logic [31:0] m_rel[2];
    bit          m_run[2];
    bit          m_auto[2];
    bit          m_irq[2];
    bit          m_exp[2];
    int unsigned m_el[2];

    task automatic model(input int i, input bit r, input bit l,
                         input logic [31:0] lv, input bit sa,
                         input bit sp, input bit au, input bit ak);
        bit fire;
        fire = 1'b0;
        if (!r) begin
            m_cnt[i] = 0;
            m_rel[i] = 0;
            m_run[i] = 0;
            m_auto[i] = 0;
            m_irq[i] = 0;
            m_el[i] = 0;
        end else begin
            if (l) begin
                m_cnt[i] = lv;
                m_rel[i] = lv;
                m_el[i] = 0;
                if (lv == 0) m_run[i] = 0;
            end else if (sp) begin
                if (m_run[i]) begin
                    m_run[i] = 0;
                    m_el[i] = 0;
                end
            end else if (sa && !m_run[i] && m_cnt[i] != 0) begin
                m_run[i] = 1;
                m_auto[i] = au;
                m_el[i] = 0;
            end else if (m_run[i]) begin
                m_el[i] = m_el[i] + 1;
                if (m_el[i] == pdiv[i]) begin
                    m_el[i] = 0;
                    if (m_cnt[i] == 1) begin
                        fire = 1'b1;
                        if (m_auto[i]) begin
                            m_cnt[i] = m_rel[i];
                        end else begin
                            m_cnt[i] = 0;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
            if (fire) m_irq[i] = 1;
            else if (ak) m_irq[i] = 0;
        end
        m_exp[i] = fire;
    endtask

    task automatic step(input bit r, input bit l,
                        input logic [31:0] lv, input bit sa,
                        input bit sp, input bit au, input bit ak);
        rst = r;
        load = l;
        load_val = lv;
        start = sa;
        stop = sp;
        auto_reload = au;
        irq_ack = ak;
        for (int i = 0; i < 2; i++) begin
            model(i, r, l, lv, sa, sp, au, ak);
        end
        q0.push_back({m_cnt[0], m_run[0], m_exp[0], m_irq[0]});
        q1.push_back({m_cnt[1], m_run[1], m_exp[1], m_irq[1]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input logic [31:0] v);
        step(1, 1, v, 0, 0, 0, 0);
    endtask

    task automatic do_start(input bit au);
        step(1, 0, 0, 1, 0, au, 0);
    endtask

    task automatic do_stop();
        step(1, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic do_ack();
        step(1, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        ncyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            g = {cnt0, running0, expire0, irq0};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pre1 cyc%0d got cnt=%h run=%b exp=%b irq=%b want cnt=%h run=%b exp=%b irq=%b",
                         ncyc, g.cnt, g.run, g.exp, g.irq,
                         e.cnt, e.run, e.exp, e.irq);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {cnt1, running1, expire1, irq1};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pre4 cyc%0d got cnt=%h run=%b exp=%b irq=%b want cnt=%h run=%b exp=%b irq=%b",
                         ncyc, g.cnt, g.run, g.exp, g.irq,
                         e.cnt, e.run, e.exp, e.irq);
            end
        end
    end

    initial begin
        bit          r, l, sa, sp, au, ak;
        logic [31:0] lv;

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        do_load(5);
        do_start(0);
        idle(8);
        do_ack();
        idle(2);

        do_load(3);
        do_start(1);
        idle(7);
        do_stop();
        idle(2);
        do_start(1);
        idle(5);
        do_stop();

        do_load(2);
        do_start(0);
        idle(10);

        do_load(1);
        do_start(0);
        idle(3);
        do_start(0);
        idle(2);

        do_load(7);
        do_start(0);
        idle(2);
        do_load(0);
        idle(2);
        do_start(0);
        idle(1);

        do_load(6);
        do_start(0);
        idle(2);
        step(1, 0, 0, 1, 1, 0, 0);
        idle(2);

        do_load(2);
        do_start(0);
        for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 0, 0, 1);

        do_load(3);
        do_start(1);
        idle(2);
        do_stop();
        idle(2);
        do_start(1);
        idle(1);
        do_load(4);
        idle(6);
        do_stop();

        do_load(32'hFFFF_FFFF);
        do_start(1);
        idle(3);
        do_load(1);
        idle(10);

        do_load(32'h1234);
        do_start(1);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int k = 0; k < 800; k++) begin
            r  = ($urandom_range(99) != 0);
            l  = ($urandom_range(19) == 0);
            case ($urandom_range(9))
                0:       lv = 0;
                1:       lv = $urandom;
                default: lv = $urandom_range(6, 1);
            endcase
            sa = ($urandom_range(5) == 0);
            sp = ($urandom_range(24) == 0);
            au = ($urandom_range(1) == 1);
            ak = ($urandom_range(5) == 0);
            step(r, l, lv, sa, sp, au, ak);
        end

        repeat (3) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0",
                     q0.size() + q1.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
